data_mem_mover: RTL

Block-transfer initiator for the 1024 x 16 data memory. It drives the memory's address, read-enable, write-enable and write-data pins and samples its read-data pin. It runs three word-serial operations on a contiguous address range: copy, pattern fill and 16-bit checksum. It sits beside the datapath as a second master to the data memory; an external mux grants it the memory port while `busy` is high.

---
 rtl/data_mem_mover.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_mover.sv
// Block-transfer initiator for the 1024 x 16 data memory: copy, pattern fill and
// 16-bit checksum over a contiguous, wrapping address range.
//
// state | meaning
// IDLE  | waiting for start; memory pins idle
// RD    | read cycle at src+i; copy captures into hold, checksum accumulates
// WR    | write cycle at dst+i; data is hold (copy) or pattern (fill)
// FIN   | one-cycle done pulse; checksum publishes acc into sum on exit
module data_mem_mover (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [9:0]  src_adr,
    input  logic [9:0]  dst_adr,
    input  logic [10:0] len,
    input  logic [15:0] pattern,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic [9:0]  Adr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [15:0] WData,
    input  logic [15:0] Data
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [1:0] M_COPY = 2'b00;
    localparam logic [1:0] M_FILL = 2'b01;
    localparam logic [1:0] M_CSUM = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;

    state_t      r_state, w_state;
    logic [1:0]  r_mode, w_mode;
    logic [9:0]  r_src, w_src;
    logic [9:0]  r_dst, w_dst;
    logic [10:0] r_len, w_len;
    logic [15:0] r_pat, w_pat;
    logic [10:0] r_idx, w_idx;
    logic [15:0] r_hold, w_hold;
    logic [15:0] r_acc, w_acc;
    logic [15:0] r_sum, w_sum;
    logic [9:0]  r_adr, w_adr;
    logic        r_rd, w_rd;
    logic        r_wr, w_wr;
    logic [15:0] r_wdata, w_wdata;
    logic [10:0] w_len_clamp;
    logic [10:0] w_idx_inc;
    logic        w_last;

    assign w_len_clamp = (len > 11'd1024) ? 11'd1024 : len;
    assign w_idx_inc   = r_idx + 11'd1;
    assign w_last      = (w_idx_inc == r_len);

    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_src   = r_src;
        w_dst   = r_dst;
        w_len   = r_len;
        w_pat   = r_pat;
        w_idx   = r_idx;
        w_hold  = r_hold;
        w_acc   = r_acc;
        w_sum   = r_sum;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode = mode;
                    w_src  = src_adr;
                    w_dst  = dst_adr;
                    w_len  = w_len_clamp;
                    w_pat  = pattern;
                    w_idx  = 11'd0;
                    if (mode == M_CSUM)
                        w_acc = 16'd0;
                    if (w_len_clamp == 11'd0 || mode == M_RSVD)
                        w_state = S_FIN;
                    else if (mode == M_FILL)
                        w_state = S_WR;
                    else
                        w_state = S_RD;
                end
            end
            S_RD: begin
                if (r_mode == M_CSUM) begin
                    w_acc = r_acc + Data;
                    w_idx = w_idx_inc;
                    if (w_last)
                        w_state = S_FIN;
                end else begin
                    w_hold  = Data;
                    w_state = S_WR;
                end
            end
            S_WR: begin
                w_idx = w_idx_inc;
                if (w_last)
                    w_state = S_FIN;
                else if (r_mode == M_COPY)
                    w_state = S_RD;
            end
            S_FIN: begin
                if (r_mode == M_CSUM)
                    w_sum = r_acc;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Pin values are computed for the upcoming state so they come straight off flops.
    always_comb begin
        w_adr   = 10'd0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_wdata = 16'd0;
        if (w_state == S_RD) begin
            w_adr = w_src + w_idx[9:0];
            w_rd  = 1'b1;
        end else if (w_state == S_WR) begin
            w_adr   = w_dst + w_idx[9:0];
            w_wr    = 1'b1;
            w_wdata = (w_mode == M_FILL) ? w_pat : w_hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= M_COPY;
            r_src   <= 10'd0;
            r_dst   <= 10'd0;
            r_len   <= 11'd0;
            r_pat   <= 16'd0;
            r_idx   <= 11'd0;
            r_hold  <= 16'd0;
            r_acc   <= 16'd0;
            r_sum   <= 16'd0;
            r_adr   <= 10'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= 16'd0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_src   <= w_src;
            r_dst   <= w_dst;
            r_len   <= w_len;
            r_pat   <= w_pat;
            r_idx   <= w_idx;
            r_hold  <= w_hold;
            r_acc   <= w_acc;
            r_sum   <= w_sum;
            r_adr   <= w_adr;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_wdata <= w_wdata;
        end
    end

    assign busy     = (r_state == S_RD) || (r_state == S_WR);
    assign done     = (r_state == S_FIN);
    assign sum      = r_sum;
    assign Adr      = r_adr;
    assign MemRead  = r_rd;
    assign MemWrite = r_wr;
    assign WData    = r_wdata;

endmodule
